// File: rtl/ifetch_unit.sv
// Instruction fetch stage: word-addressed instruction memory, 32-bit PC and an
// IDLE/RUN/HALT control FSM producing one registered instruction per cycle on ibus.
module ifetch_unit #(
    parameter int unsigned AW        = 6,
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'hFC000000,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [31:0]   ibus,
    output logic [31:0]   pc_out,
    output logic          ivalid,
    output logic          halted
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ibus_n, pc_out_n;
    logic        ivalid_n, halted_n;

    logic [31:0] mem [DEPTH];
    logic [31:0] fetch_word;
    logic        mem_we;

    // Combinational read; upper PC bits alias onto the memory index.
    assign fetch_word = mem[pc[AW+1:2]];

    // Program port is only honoured while the fetcher is not running.
    assign mem_we = prog_we && !reset && (state != ST_RUN);

    // Instruction memory write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Next-state and next-output logic; redirect beats stall beats halt detection.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ibus_n   = ibus;
        pc_out_n = pc_out;
        ivalid_n = ivalid;
        halted_n = halted;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    pc_n    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_n     = redirect_pc & ~32'd3;
                    ibus_n   = NOP_WORD;
                    ivalid_n = 1'b0;
                end else if (stall) begin
                    // all registers hold
                end else if (fetch_word == HALT_WORD) begin
                    ibus_n   = NOP_WORD;
                    ivalid_n = 1'b0;
                    state_n  = ST_HALT;
                    halted_n = 1'b1;
                end else begin
                    ibus_n   = fetch_word;
                    pc_out_n = pc;
                    ivalid_n = 1'b1;
                    pc_n     = pc + 32'd4;
                end
            end
            ST_HALT: begin
                ibus_n   = NOP_WORD;
                ivalid_n = 1'b0;
                halted_n = 1'b1;
                if (start) begin
                    state_n  = ST_RUN;
                    pc_n     = RESET_PC;
                    halted_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            ibus   <= NOP_WORD;
            pc_out <= '0;
            ivalid <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ibus   <= ibus_n;
            pc_out <= pc_out_n;
            ivalid <= ivalid_n;
            halted <= halted_n;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a scoreboard queue of expected outputs.
module tb_ifetch_unit;

    localparam logic [31:0] HALTW = 32'hFC000000;
    localparam logic [31:0] NOP   = 32'h00000000;
    localparam logic [31:0] W0    = 32'h00221820;
    localparam logic [31:0] W1    = 32'h00432020;
    localparam logic [31:0] W2    = 32'h00642820;
    localparam logic [31:0] W8    = 32'h00A63820;
    localparam logic [31:0] W63   = 32'h12345678;
    localparam logic [31:0] WNEW  = 32'h11111111;

    logic        clk = 1'b0;
    logic        reset, start, stall, redirect, prog_we;
    logic [31:0] redirect_pc, prog_data;
    logic [5:0]  prog_addr;
    logic [31:0] ibus, pc_out;
    logic        ivalid, halted;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [31:0] ib;
        logic [31:0] pc;
        logic        iv;
        logic        h;
    } exp_t;

    exp_t sb[$];

    ifetch_unit #(
        .AW(6),
        .RESET_PC(32'h00000000),
        .HALT_WORD(32'hFC000000),
        .NOP_WORD(32'h00000000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .ibus(ibus),
        .pc_out(pc_out),
        .ivalid(ivalid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Push the expectation for the coming edge, clock once, then pop and compare.
    task automatic step(input string tag, input logic [31:0] eib, input logic [31:0] epc,
                        input logic eiv, input logic eh);
        exp_t e;
        sb.push_back('{ib: eib, pc: epc, iv: eiv, h: eh});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (ibus === e.ib) else begin
            fails++;
            $error("FAIL %s ibus observed %h expected %h", tag, ibus, e.ib);
        end
        checks++;
        assert (pc_out === e.pc) else begin
            fails++;
            $error("FAIL %s pc_out observed %h expected %h", tag, pc_out, e.pc);
        end
        checks++;
        assert (ivalid === e.iv) else begin
            fails++;
            $error("FAIL %s ivalid observed %b expected %b", tag, ivalid, e.iv);
        end
        checks++;
        assert (halted === e.h) else begin
            fails++;
            $error("FAIL %s halted observed %b expected %b", tag, halted, e.h);
        end
    endtask

    logic [5:0]  ld_addr [7];
    logic [31:0] ld_data [7];

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        ld_addr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd8, 6'd9, 6'd63};
        ld_data = '{W0, W1, W2, HALTW, W8, HALTW, W63};

        // reset state
        step("reset0", NOP, 32'h0, 1'b0, 1'b0);
        step("reset1", NOP, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // load program in IDLE; outputs stay at reset values
        prog_we = 1'b1;
        for (int i = 0; i < 7; i++) begin
            prog_addr = ld_addr[i];
            prog_data = ld_data[i];
            step("idle_load", NOP, 32'h0, 1'b0, 1'b0);
        end
        prog_we = 1'b0;

        // start, stream three words, stop on halt word
        start = 1'b1;
        step("start", NOP, 32'h0, 1'b0, 1'b0);
        start = 1'b0;
        step("fetch0", W0, 32'h0, 1'b1, 1'b0);
        step("fetch1", W1, 32'h4, 1'b1, 1'b0);
        step("fetch2", W2, 32'h8, 1'b1, 1'b0);
        step("halt_det", NOP, 32'h8, 1'b0, 1'b1);
        step("halt_hold", NOP, 32'h8, 1'b0, 1'b1);

        // restart from HALT, stall 3 cycles on W1
        start = 1'b1;
        step("restart", NOP, 32'h8, 1'b0, 1'b0);
        start = 1'b0;
        step("rs_fetch0", W0, 32'h0, 1'b1, 1'b0);
        step("rs_fetch1", W1, 32'h4, 1'b1, 1'b0);
        stall = 1'b1;
        step("stall1", W1, 32'h4, 1'b1, 1'b0);
        step("stall2", W1, 32'h4, 1'b1, 1'b0);
        step("stall3", W1, 32'h4, 1'b1, 1'b0);
        stall = 1'b0;
        // program write and start during RUN must be ignored
        prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'hDEADBEEF; start = 1'b1;
        step("post_stall", W2, 32'h8, 1'b1, 1'b0);
        prog_we = 1'b0; start = 1'b0;
        step("halt_det2", NOP, 32'h8, 1'b0, 1'b1);

        // write in HALT, restart, then redirect together with stall
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = WNEW;
        step("halt_write", NOP, 32'h8, 1'b0, 1'b1);
        prog_we = 1'b0;
        start = 1'b1;
        step("restart2", NOP, 32'h8, 1'b0, 1'b0);
        start = 1'b0;
        step("new_word", WNEW, 32'h0, 1'b1, 1'b0);
        step("run_we_ignored", W1, 32'h4, 1'b1, 1'b0);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h00000022;
        step("redir_bubble", NOP, 32'h4, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step("redir_target", W8, 32'h20, 1'b1, 1'b0);
        step("halt_det3", NOP, 32'h20, 1'b0, 1'b1);

        // reset mid-run (with stall and redirect asserted), memory retained
        start = 1'b1;
        step("restart3", NOP, 32'h20, 1'b0, 1'b0);
        start = 1'b0;
        step("r3_fetch0", WNEW, 32'h0, 1'b1, 1'b0);
        step("r3_fetch1", W1, 32'h4, 1'b1, 1'b0);
        reset = 1'b1; stall = 1'b1; redirect = 1'b1;
        step("run_reset", NOP, 32'h0, 1'b0, 1'b0);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        step("idle_after_rst", NOP, 32'h0, 1'b0, 1'b0);
        start = 1'b1;
        step("start_after_rst", NOP, 32'h0, 1'b0, 1'b0);
        start = 1'b0;
        step("refetch0", WNEW, 32'h0, 1'b1, 1'b0);

        // redirect to top of address space; PC wraps to 0
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step("wrap_bubble", NOP, 32'h0, 1'b0, 1'b0);
        redirect = 1'b0;
        step("wrap_top", W63, 32'hFFFFFFFC, 1'b1, 1'b0);
        step("wrap_zero", WNEW, 32'h0, 1'b1, 1'b0);
        step("wrap_next", W1, 32'h4, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that produces the `ibus` instruction stream consumed by the decode/register-read/ALU pipeline. Holds a word-addressed instruction memory, a 32-bit program counter and a small control FSM. Issues one registered instruction per cycle, honours downstream stall and branch redirect, injects NOPs on flush, and stops on a halt word. Memory is loadable through a program port while the fetcher is idle or halted.

## Interface
Parameters:
- AW, 6, instruction memory address width; depth is 2^AW words.
- RESET_PC, 32'h00000000, PC value loaded on reset and on restart from HALT.
- HALT_WORD, 32'hFC000000, instruction encoding that stops fetch.
- NOP_WORD, 32'h00000000, encoding driven on `ibus` when no valid instruction is issued.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE or HALT and begin fetching.
- stall  in  1  hold PC, `ibus`, `pc_out` and `ivalid` unchanged.
- redirect  in  1  flush and load the PC from `redirect_pc`.
- redirect_pc  in  32  branch/jump target; bits [1:0] ignored.
- prog_we  in  1  instruction memory write strobe.
- prog_addr  in  AW  word address for program writes.
- prog_data  in  32  word to write.
- ibus  out  32  registered instruction to decode.
- pc_out  out  32  byte address of the instruction on `ibus`.
- ivalid  out  1  `ibus` holds a real fetched instruction.
- halted  out  1  FSM is in HALT.

## Operation
- States: IDLE, RUN, HALT. Reset forces IDLE, pc=RESET_PC, ibus=NOP_WORD, pc_out=0, ivalid=0, halted=0. Memory contents are not cleared by reset.
- IDLE: outputs hold reset values. `prog_we` writes mem[prog_addr]=prog_data. `start` moves to RUN with pc=RESET_PC.
- RUN, evaluated each edge in this priority:
  1. `redirect`: pc<=redirect_pc with [1:0] forced to 0; ibus<=NOP_WORD; ivalid<=0. Redirect wins over stall and halt detection.
  2. `stall`: all registers hold.
  3. Fetched word w=mem[pc[AW+1:2]] equals HALT_WORD: ibus<=NOP_WORD, ivalid<=0, pc holds, state<=HALT, halted<=1.
  4. Otherwise: ibus<=w, pc_out<=pc, ivalid<=1, pc<=pc+4.
- PC arithmetic: 32-bit, wraps 32'hFFFFFFFC to 0. Memory index uses pc[AW+1:2] only; upper bits alias.
- In RUN, `prog_we` and `start` are ignored.
- HALT: ibus=NOP_WORD, ivalid=0, halted=1. `prog_we` writes are accepted. `start` moves to RUN with pc=RESET_PC and halted<=0.
- `reset` overrides everything in every state, including mid-stall and mid-redirect.
- Memory read is combinational from pc. Writes occur at the clock edge; a same-edge write and read of one address returns the old word.

## Timing
- Fetch latency: the instruction at pc appears on `ibus` one edge after it is addressed. Throughput is 1 per cycle when not stalled.
- `start` sampled at edge n: state=RUN after n. The first instruction (RESET_PC) is on `ibus` after edge n+1.
- `redirect` sampled at edge k: NOP bubble (ivalid=0) after k. The word at redirect_pc is on `ibus` after edge k+1.
- `stall` high for m cycles freezes the outputs for exactly m cycles. No instruction is lost or duplicated.
- `halted` rises on the same edge the halt word is detected. The halt word itself is never presented as valid.

## Test plan
- Load mem[0..3]={0x00221820, 0x00432020, 0x00642820, HALT_WORD} in IDLE, then pulse start -> ibus shows the three words with pc_out=0, 4, 8 and ivalid=1 on consecutive cycles, then ivalid=0 and halted=1; pc holds 12.
- While streaming, hold stall for 3 cycles with ibus=0x00432020 -> ibus, pc_out and ivalid stay unchanged for 3 cycles, then 0x00642820 follows.
- Redirect to 0x20 with mem[8]=0x00A63820, asserted together with stall -> one NOP cycle with ivalid=0, then ibus=0x00A63820 and pc_out=0x20.
- Assert reset during RUN at pc=0x8 -> next edge: IDLE, ibus=0, ivalid=0, pc_out=0; memory retained, and a subsequent start refetches mem[0].
- In HALT, write mem[0]=0x11111111, then start -> ibus=0x11111111 at pc_out=0; a prog_we issued during RUN leaves memory unchanged.
- Redirect to 0xFFFFFFFC with AW=6 -> fetches mem[63], and the next pc wraps to 0x00000000.
